// File: rtl/bram_pingpong_writer.sv
// bram_pingpong_writer: streams generator words into BRAM port A as a two-half ping-pong ring
// Ports:
//   i_clk, i_rst          clock (also BRAM porta_clk), async active-high reset
//   i_enable              1 = run, 0 = stop and rewind to word 0
//   i_s_valid/i_s_data    generator word; o_s_ready accepts it
//   o_bram_en/we/addr/din BRAM port A write, one cycle after the accept
//   i_half_release        per-half pulse from software: half consumed
//   o_half_full           per-half ownership: 1 = full, awaiting reader
//   o_half_done/_idx      1-cycle pulse and index when a half's last word is written
//   o_word_count          words accepted since enable rose (wraps)
//   o_stall_count         cycles with valid held and not ready while running (saturates)
module bram_pingpong_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8192
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_s_valid,
  input  logic [DATA_WIDTH-1:0]   i_s_data,
  output logic                    o_s_ready,
  output logic                    o_bram_en,
  output logic [DATA_WIDTH/8-1:0] o_bram_we,
  output logic [ADDR_WIDTH-1:0]   o_bram_addr,
  output logic [DATA_WIDTH-1:0]   o_bram_din,
  input  logic [1:0]              i_half_release,
  output logic [1:0]              o_half_full,
  output logic                    o_half_done,
  output logic                    o_half_done_idx,
  output logic [31:0]             o_word_count,
  output logic [31:0]             o_stall_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;
  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr;
  logic [1:0]            r_full, w_full, w_set;
  logic                  r_en, r_done, r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [31:0]           r_wc, r_sc;
  logic                  w_hf, w_acc, w_last, w_stop, w_start, w_stall;
  // ownership bit of the half the write pointer currently targets
  assign w_hf      = r_full[r_ptr[PW-1]];
  assign o_s_ready = (r_state == S_RUN) & ~w_hf;
  assign w_acc     = i_s_valid & o_s_ready;
  assign w_last    = &r_ptr[PW-2:0];
  assign w_stop    = (r_state != S_IDLE) & ~i_enable;
  assign w_start   = (r_state == S_IDLE) & i_enable;
  assign w_stall   = (r_state != S_IDLE) & i_s_valid & ~o_s_ready & ~&r_sc;
  // completing a half beats a release of the same half in the same cycle
  assign w_set  = {2{w_acc & w_last}} & {r_ptr[PW-1], ~r_ptr[PW-1]};
  assign w_full = w_stop ? 2'b00 : w_set | (r_full & ~i_half_release);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_enable ? S_RUN : S_IDLE;
      S_RUN:   w_next = !i_enable ? S_IDLE : w_hf ? S_WAIT : S_RUN;
      S_WAIT:  w_next = !i_enable ? S_IDLE : w_hf ? S_WAIT : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_full  <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_wc    <= '0;
      r_sc    <= '0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_stop ? '0 : r_ptr + PW'(w_acc);
      r_full  <= w_full;
      r_en    <= w_acc;
      r_done  <= w_acc & w_last;
      if (w_acc) begin
        r_addr <= ADDR_WIDTH'({r_ptr, 3'b000});
        r_din  <= i_s_data;
      end
      if (w_acc & w_last) r_idx <= r_ptr[PW-1];
      r_wc <= w_start ? '0 : r_wc + 32'(w_acc);
      r_sc <= w_start ? '0 : r_sc + 32'(w_stall);
    end
  end
  assign o_bram_en       = r_en;
  assign o_bram_we       = {(DATA_WIDTH/8){r_en}};
  assign o_bram_addr     = r_addr;
  assign o_bram_din      = r_din;
  assign o_half_full     = r_full;
  assign o_half_done     = r_done;
  assign o_half_done_idx = r_idx;
  assign o_word_count    = r_wc;
  assign o_stall_count   = r_sc;
endmodule

// File: tb/tb_bram_pingpong_writer.sv
// tb_bram_pingpong_writer: directed table, corner sequences and random stream against a ring model
module tb_bram_pingpong_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, sv = 1'b0;
  logic [63:0] sd = '0;
  logic [1:0]  rel = '0;
  logic        rdy, ben, done, idx;
  logic [7:0]  bwe;
  logic [15:0] addr;
  logic [63:0] din;
  logic [1:0]  full;
  logic [31:0] wc, sc;
  int checks = 0, errors = 0;

  bram_pingpong_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .DEPTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_s_valid(sv), .i_s_data(sd),
    .o_s_ready(rdy), .o_bram_en(ben), .o_bram_we(bwe), .o_bram_addr(addr),
    .o_bram_din(din), .i_half_release(rel), .o_half_full(full),
    .o_half_done(done), .o_half_done_idx(idx), .o_word_count(wc), .o_stall_count(sc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en, v; logic [63:0] d; logic [1:0] rel;
    logic rdy, ben; logic [15:0] addr; logic [63:0] din; logic done, idx; logic [1:0] full;
  } vec_t;
  vec_t tv [23];

  function automatic vec_t mk(input logic e, v, input logic [63:0] d, input logic [1:0] r,
                              input logic rd, be, input logic [15:0] a, input logic [63:0] di,
                              input logic dn, ix, input logic [1:0] f);
    mk = '{e, v, d, r, rd, be, a, di, dn, ix, f};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, v, input logic [63:0] d, input logic [1:0] r);
    @(posedge clk);
    #1;
    en = e; sv = v; sd = d; rel = r;
    @(negedge clk);
  endtask

  logic [3:0]  mptr;
  logic [1:0]  mfull, nf, rr;
  logic        pend, acc;
  logic [15:0] paddr;
  logic [63:0] pdata;
  int          tmr [2];
  int          words, cyc, shown;

  initial begin
    tv[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    for (int i = 0; i < 8; i++)
      tv[1+i] = mk(1, 1, 64'(100+i), 0, 1, i > 0, 16'((i-1)*8), 64'(100+i-1), 0, 0, 2'b00);
    tv[9] = mk(1, 0, 0, 0, 1, 1, 16'h38, 64'd107, 1, 0, 2'b01);
    for (int i = 0; i < 8; i++)
      tv[10+i] = mk(1, 1, 64'(108+i), 0, 1, i > 0, 16'(64+(i-1)*8), 64'(108+i-1), 0, 0, 2'b01);
    tv[18] = mk(1, 1, 64'd200, 2'b00, 0, 1, 16'h78, 64'd115, 1, 1, 2'b11);
    tv[19] = mk(1, 1, 64'd200, 2'b01, 0, 0, 0, 0, 0, 0, 2'b11);
    tv[20] = mk(1, 1, 64'd200, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10);
    tv[21] = mk(1, 1, 64'd200, 2'b00, 1, 0, 0, 0, 0, 0, 2'b10);
    tv[22] = mk(1, 0, 0, 2'b00, 1, 1, 16'h00, 64'd200, 0, 0, 2'b10);

    #12;
    chk("reset_outputs", {rdy, ben, bwe, addr, din[15:0], full, done, idx},  '0);
    chk("reset_counts", {wc, sc}, '0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tv[i].en, tv[i].v, tv[i].d, tv[i].rel);
      chk($sformatf("v%0d_ready", i), rdy, tv[i].rdy);
      chk($sformatf("v%0d_en", i), ben, tv[i].ben);
      chk($sformatf("v%0d_full", i), full, tv[i].full);
      chk($sformatf("v%0d_done", i), done, tv[i].done);
      if (tv[i].ben) begin
        chk($sformatf("v%0d_we", i), bwe, 8'hFF);
        chk($sformatf("v%0d_addr", i), addr, tv[i].addr);
        chk($sformatf("v%0d_din", i), din, tv[i].din);
      end
      if (tv[i].done) chk($sformatf("v%0d_idx", i), idx, tv[i].idx);
    end
    chk("stall_count", sc, 3);
    chk("word_count", wc, 17);

    for (int i = 1; i < 7; i++) drive(1, 1, 64'(300+i), 2'b00);
    drive(1, 1, 64'd307, 2'b01);
    drive(1, 0, 0, 2'b00);
    chk("setwins_full", full, 2'b11);
    chk("setwins_done", {done, idx, addr, din}, {1'b1, 1'b0, 16'h38, 64'd307});
    chk("setwins_ready", rdy, 0);
    drive(1, 0, 0, 2'b10);
    drive(1, 0, 0, 2'b00);
    chk("release1_full", full, 2'b01);
    drive(1, 0, 0, 2'b10);
    drive(1, 0, 0, 2'b00);
    chk("release_empty_full", full, 2'b01);
    drive(1, 0, 0, 2'b11);
    drive(1, 0, 0, 2'b00);
    chk("release_both_full", full, 2'b00);
    chk("release_both_ready", rdy, 1);

    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 64'(500+i), 0);
    drive(0, 1, 64'd504, 0);
    chk("drop_accept_ready", rdy, 1);
    drive(0, 0, 0, 0);
    chk("drop_write", {ben, addr, din}, {1'b1, 16'h20, 64'd504});
    chk("drop_word_count", wc, 5);
    chk("drop_ready", rdy, 0);
    drive(0, 0, 0, 0);
    chk("idle_quiet", {rdy, ben, full}, '0);
    drive(1, 0, 0, 0);
    chk("reen_hold_count", wc, 5);
    drive(1, 1, 64'hAA, 0);
    chk("reen_ready", rdy, 1);
    chk("reen_count_clear", wc, 0);
    drive(1, 0, 0, 0);
    chk("reen_write", {ben, addr, din, full}, {1'b1, 16'h00, 64'hAA, 2'b00});
    chk("reen_word_count", wc, 1);

    drive(1, 1, 64'h55, 0);
    @(posedge clk);
    #2 rst = 1'b1; en = 0; sv = 0;
    #1;
    chk("async_reset_outputs", {rdy, ben, bwe, addr, din, full, done, idx}, '0);
    chk("async_reset_counts", {wc, sc}, '0);
    @(posedge clk); #1 rst = 1'b0;

    mptr = 0; mfull = 0; pend = 0; paddr = 0; pdata = 0;
    tmr[0] = 0; tmr[1] = 0; words = 0; cyc = 0; shown = 0;
    drive(1, 0, 0, 0);
    while (words < 10000 && cyc < 60000) begin
      @(posedge clk);
      #1;
      rr = {tmr[1] == 1, tmr[0] == 1};
      for (int h = 0; h < 2; h++) if (tmr[h] > 0) tmr[h]--;
      sv = 1'($urandom % 2);
      sd = {$urandom, $urandom};
      rel = rr;
      @(negedge clk);
      cyc++;
      checks++;
      if (full !== mfull || (pend ? (ben !== 1'b1 || bwe !== 8'hFF || addr !== paddr || din !== pdata)
                                  : ben !== 1'b0) || (rdy && mfull[mptr[3]])) begin
        errors++;
        if (shown++ < 10)
          $display("FAIL rand_cycle%0d: full=%b en=%b addr=%h din=%h ready=%b expected full=%b en=%b addr=%h din=%h",
                   cyc, full, ben, addr, din, rdy, mfull, pend, paddr, pdata);
      end
      acc = sv & rdy;
      nf = mfull & ~rr;
      if (acc && mptr[2:0] == 3'd7) nf[mptr[3]] = 1'b1;
      for (int h = 0; h < 2; h++) if (nf[h] && !mfull[h]) tmr[h] = int'($urandom_range(1, 8));
      pend = acc;
      if (acc) begin
        paddr = {9'd0, mptr, 3'b000};
        pdata = sd;
      end
      mptr = mptr + 4'(acc);
      mfull = nf;
      words += int'(acc);
    end
    chk("rand_words_done", (words >= 10000), 1);
    @(posedge clk);
    #1 sv = 0; rel = 0;
    @(negedge clk);
    chk("rand_last_write", {ben, addr, din}, {pend, pend ? paddr : addr, pend ? pdata : din});
    chk("rand_word_count", wc, 32'(words));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
